// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtractor: feeds a 1-bit full-subtractor one operand bit per clock,
// LSB first, through a registered borrow, and reports diff / borrow_out / zero with a done pulse.
module serial_sub_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         zero
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_r;
    logic [W-1:0]  a_sh_r;
    logic [W-1:0]  b_sh_r;
    logic [W-1:0]  res_sh_r;
    logic          borrow_r;
    logic [CW-1:0] cnt_r;

    logic          sub_s;
    logic          borrow_s;
    logic [W-1:0]  res_next_s;

    // 1-bit full-subtractor cell equations; returns {Borrow, Sub}
    function automatic logic [1:0] full_sub(input logic a_bit, input logic b_bit, input logic c_bit);
        logic s_v;
        logic bo_v;
        s_v  = a_bit ^ b_bit ^ c_bit;
        bo_v = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & c_bit);
        return {bo_v, s_v};
    endfunction

    // Cell evaluation on the current LSBs and the next result shift-register value
    always_comb begin
        {borrow_s, sub_s} = full_sub(a_sh_r[0], b_sh_r[0], borrow_r);
        res_next_s        = res_sh_r >> 1'b1;
        res_next_s[W-1]   = sub_s;
    end

    // Control FSM with registered outputs and datapath shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            a_sh_r     <= {W{1'b0}};
            b_sh_r     <= {W{1'b0}};
            res_sh_r   <= {W{1'b0}};
            borrow_r   <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= {W{1'b0}};
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        borrow_r <= borrow_in;
                        cnt_r    <= {CW{1'b0}};
                        busy     <= 1'b1;
                        state_r  <= ST_SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    res_sh_r <= res_next_s;
                    a_sh_r   <= a_sh_r >> 1'b1;
                    b_sh_r   <= b_sh_r >> 1'b1;
                    borrow_r <= borrow_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == LAST_CNT) begin
                        // result outputs update only here, on the final bit
                        diff       <= res_next_s;
                        borrow_out <= borrow_s;
                        zero       <= (res_next_s == {W{1'b0}});
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        busy    <= 1'b1;
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized self-checking bench for serial_sub_ctrl (W=8 and W=1 instances)
// against an arithmetic reference model of a - b - borrow_in.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bi8, busy8, done8, bo8, zero8;
    logic [7:0] a8, b8, diff8;
    logic       start1, bi1, busy1, done1, bo1, zero1;
    logic [0:0] a1, b1, diff1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] last_diff = 8'h00;
    logic       last_bo   = 1'b0;
    logic       last_zero = 1'b0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .zero(zero8)
    );

    serial_sub_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .borrow_in(bi1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1), .zero(zero1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: 9-bit arithmetic, bit 8 is the borrow out
    function automatic logic [8:0] ref_sub(input logic [7:0] av, input logic [7:0] bv, input logic c);
        return {1'b0, av} - {1'b0, bv} - {8'h00, c};
    endfunction

    // One operation on the W=8 instance; returns at the sample point where done is high.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic c, input int poke);
        logic [8:0] r;
        int nb;
        int guard;
        r = ref_sub(av, bv, c);
        a8 = av; b8 = bv; bi8 = c; start8 = 1'b1;
        @(negedge clk);
        check("busy_first", busy8, 1);
        start8 = 1'b0;
        nb = 0;
        guard = 0;
        while (!done8 && guard < 40) begin
            if (busy8) nb++;
            check("diff_held", diff8, last_diff);
            check("bo_held", bo8, last_bo);
            a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
            if (nb == poke) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start8 = 1'b0;
        check("done_seen", done8, 1);
        check("busy_cycles", nb, 8);
        check("busy_at_done", busy8, 0);
        check("diff", diff8, r[7:0]);
        check("borrow_out", bo8, r[8]);
        check("zero", zero8, (r[7:0] == 8'h00));
        last_diff = r[7:0];
        last_bo   = r[8];
        last_zero = (r[7:0] == 8'h00);
    endtask

    task automatic step_idle();
        @(negedge clk);
        check("done_one_cycle", done8, 0);
        check("idle_not_busy", busy8, 0);
        check("diff_after", diff8, last_diff);
        check("zero_after", zero8, last_zero);
    endtask

    task automatic reset_mid_op();
        bit saw_done;
        a8 = 8'h35; b8 = 8'h12; bi8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_test_busy", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_bo", bo8, 0);
        check("rst_zero", zero8, 0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw_done |= done8;
        end
        check("rst_no_done", saw_done, 0);
        last_diff = 8'h00; last_bo = 1'b0; last_zero = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bi8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_diff", diff8, 0);
        check("reset_bo", bo8, 0);
        check("reset_zero", zero8, 0);
        check("reset_busy_w1", busy1, 0);
        check("reset_diff_w1", diff1, 0);

        run_op(8'h35, 8'h12, 1'b0, 0); step_idle();
        run_op(8'h12, 8'h35, 1'b0, 0); step_idle();
        run_op(8'h00, 8'h00, 1'b1, 0); step_idle();
        run_op(8'h80, 8'h7F, 1'b1, 3); step_idle();

        reset_mid_op();
        run_op(8'h35, 8'h12, 1'b0, 0); step_idle();

        // back-to-back: start presented in the DONE cycle
        run_op(8'h5A, 8'hC3, 1'b1, 0);
        run_op(8'h0A, 8'h03, 1'b0, 0); step_idle();

        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 9)));
            if (i % 3 != 0) step_idle();
        end
        step_idle();

        for (int k = 0; k < 8; k++) begin
            int d;
            a1 = k[2]; b1 = k[1]; bi1 = k[0]; start1 = 1'b1;
            d = int'(k[2]) - int'(k[1]) - int'(k[0]);
            @(negedge clk);
            start1 = 1'b0;
            check("w1_busy", busy1, 1);
            @(negedge clk);
            check("w1_done", done1, 1);
            check("w1_diff", diff1, d & 1);
            check("w1_borrow", bo1, (d < 0));
            check("w1_zero", zero1, ((d & 1) == 0));
            @(negedge clk);
            check("w1_done_drop", done1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial W-bit subtractor controller built around one instance of the team's Full_subtractor cell (ports A, B, C, Sub, Borrow; Sub = A^B^C, Borrow = (~A&B) | (~(A^B)&C)).
- Accepts a start request, then feeds the cell one operand bit per clock, LSB first, through a registered borrow chain.
- Returns the W-bit difference a - b - borrow_in with borrow-out and zero flags, and a one-cycle done pulse.
- Serves as the area-minimal subtract engine for multi-bit arithmetic, reusing the verified 1-bit cell.

Parameters:
- W, 8, operand/result width in bits; legal range W >= 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  W  minuend; captured on accepted start.
- b  input  W  subtrahend; captured on accepted start.
- borrow_in  input  1  initial borrow; captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when result registers update.
- diff  output  W  registered difference; held until next completion.
- borrow_out  output  1  final borrow (1 = a < b + borrow_in unsigned); held.
- zero  output  1  registered, high when diff == 0; held.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, diff=0, borrow_out=0, zero=0. Internal operand, result and borrow shift registers and the bit counter also reset to 0.
- FSM states: IDLE, SHIFT, DONE. busy=1 only in SHIFT. done=1 only in DONE.
- IDLE, start=1: latch a, b into shift regs, borrow_in into borrow reg, counter=0, next state SHIFT. IDLE, start=0: stay in IDLE.
- SHIFT, each cycle:
  - cell inputs are A=a_sh[0], B=b_sh[0], C=borrow_reg.
  - res_sh <= {Sub, res_sh[W-1:1]}; a_sh and b_sh shift right by 1; borrow_reg <= Borrow; counter++.
- SHIFT, last cycle (counter == W-1):
  - at that edge, diff <= {Sub, res_sh[W-1:1]}, borrow_out <= Borrow, zero <= (that value == 0).
  - next state DONE.
- DONE: lasts exactly one cycle. start=1 is accepted exactly as in IDLE (back-to-back op, next state SHIFT); otherwise next state IDLE.
- Latency: start sampled at edge E0; SHIFT occupies W cycles (edges E1..EW); done is high for the cycle after EW. Throughput is one op per W+1 cycles.
- start while busy (SHIFT) is ignored; a, b and borrow_in changes during SHIFT have no effect.
- diff, borrow_out and zero change only at the last-SHIFT edge or on reset, never at any other time.
- rst mid-operation: aborts immediately to IDLE with all outputs at reset values; no done pulse. rst has priority over start.
- W=1: exactly one SHIFT cycle; the result equals the cell truth table.
- Counter width is $clog2(W)+1 bits; no wrap occurs within an op.

Test Plan:
- W=8, a=0x35, b=0x12, borrow_in=0, start 1 cycle -> busy high 8 cycles; done 1 cycle; diff=0x23, borrow_out=0, zero=0.
- W=8, a=0x12, b=0x35, borrow_in=0 -> diff=0xDD, borrow_out=1. Repeat with a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1.
- W=8, a=0x80, b=0x7F, borrow_in=1 -> diff=0x00, zero=1, borrow_out=0. Pulse start with a=0xFF, b=0x01 during SHIFT cycle 3 -> ignored; result unchanged.
- rst asserted in SHIFT cycle 4 of an op -> next cycle busy=0, done never pulses, diff=0, borrow_out=0, zero=0. A subsequent op computes correctly.
- start held high through DONE with a=0x0A, b=0x03, borrow_in=0 -> second op accepted with no IDLE gap; busy=1 the cycle after done; second done yields diff=0x07.
- W=1 instance, all 8 (a,b,borrow_in) combos 000..111 -> (diff, borrow_out) = 00, 11, 11, 01, 10, 00, 00, 11.
